// File: rtl/p88_image_loader.sv
// rtl/p88_image_loader.sv - P88 image loader: ioctl byte stream to Konix RAM sections and ROM boot vector
module p88_image_loader #(
  parameter int ADDR_W       = 20,
  parameter int ROM_AW       = 3,
  parameter int ROM_VEC_BASE = 0,
  parameter int WR_PULSE     = 1,
  parameter int SEC_W        = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              load_reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  output logic              ram_we,
  output logic              rom_we,
  output logic              entry_valid,
  output logic [15:0]       entry_seg,
  output logic [15:0]       entry_off,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [SEC_W-1:0]  sections
);

  localparam int PW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
  localparam int BW = (ADDR_W > 20) ? ADDR_W : 20;
  localparam logic [ROM_AW-1:0] ROM_BASE = ROM_AW'(ROM_VEC_BASE);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_C8HDR, S_CAHDR, S_DATA, S_WR, S_NEXT, S_VEC, S_ERR
  } state_t;

  state_t              r_state, w_state_n, w_cur;
  logic                r_dl_q;
  logic [2:0]          r_hidx, w_hidx_n;
  logic [15:0]         r_seg, w_seg_n, r_off, w_off_n, r_rem, w_rem_n;
  logic [ADDR_W-1:0]   r_ptr, w_ptr_n, r_addr, w_addr_n;
  logic [PW-1:0]       r_pcnt, w_pcnt_n;
  logic [2:0]          r_vidx, w_vidx_n;
  logic                r_wait, w_wait_n, r_lrst, w_lrst_n;
  logic [7:0]          r_dout, w_dout_n;
  logic                r_ram_we, w_ram_we_n, r_rom_we, w_rom_we_n;
  logic                r_ev, w_ev_n, r_done, w_done_n, r_err, w_err_n;
  logic [15:0]         r_eseg, w_eseg_n, r_eoff, w_eoff_n;
  logic [1:0]          r_code, w_code_n;
  logic [SEC_W-1:0]    r_sec, w_sec_n, w_sec_inc;
  logic                w_rise, w_fall, w_take, w_pulse_end;
  logic [BW-1:0]       w_base_full;
  logic [15:0]         w_len;

  assign w_rise      = ioctl_download & ~r_dl_q;
  assign w_fall      = ~ioctl_download & r_dl_q;
  assign w_take      = ioctl_wr & ioctl_download & ~r_wait;
  assign w_pulse_end = (r_pcnt == PW'(WR_PULSE - 1));
  assign w_sec_inc   = (r_sec == {SEC_W{1'b1}}) ? r_sec : r_sec + SEC_W'(1);
  assign w_base_full = BW'({r_seg, 4'b0000}) + BW'(r_off);
  assign w_len       = {ioctl_dout, r_rem[7:0]};

  // Boot vector layout: far JMP opcode, then offset and segment little-endian
  function automatic logic [7:0] vec_byte(input logic [2:0] idx, input logic [15:0] seg,
                                          input logic [15:0] off);
    case (idx)
      3'd0:    vec_byte = 8'hEA;
      3'd1:    vec_byte = off[7:0];
      3'd2:    vec_byte = off[15:8];
      3'd3:    vec_byte = seg[7:0];
      default: vec_byte = seg[15:8];
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] rom_addr(input logic [2:0] idx);
    logic [ROM_AW-1:0] a;
    a = ROM_BASE + ROM_AW'(idx);
    rom_addr = ADDR_W'(a);
  endfunction

  // Next-state and next-output logic for the parser and strobe sequencer
  always_comb begin
    w_state_n  = r_state;
    w_cur      = r_state;
    w_hidx_n   = r_hidx;
    w_seg_n    = r_seg;
    w_off_n    = r_off;
    w_rem_n    = r_rem;
    w_ptr_n    = r_ptr;
    w_pcnt_n   = r_pcnt;
    w_vidx_n   = r_vidx;
    w_wait_n   = r_wait;
    w_lrst_n   = r_lrst;
    w_addr_n   = r_addr;
    w_dout_n   = r_dout;
    w_ram_we_n = r_ram_we;
    w_rom_we_n = r_rom_we;
    w_ev_n     = r_ev;
    w_eseg_n   = r_eseg;
    w_eoff_n   = r_eoff;
    w_done_n   = 1'b0;
    w_err_n    = r_err;
    w_code_n   = r_code;
    w_sec_n    = r_sec;

    if (w_rise) begin
      w_lrst_n   = 1'b1;
      w_err_n    = 1'b0;
      w_code_n   = 2'b00;
      w_sec_n    = '0;
      w_ev_n     = 1'b0;
      w_wait_n   = 1'b0;
      w_ram_we_n = 1'b0;
      w_rom_we_n = 1'b0;
      w_cur      = S_CMD;
      w_state_n  = S_CMD;
    end

    if (w_fall) begin
      w_state_n  = S_IDLE;
      w_wait_n   = 1'b0;
      w_lrst_n   = 1'b0;
      w_ram_we_n = 1'b0;
      w_rom_we_n = 1'b0;
      if (!r_err) begin
        if (r_state == S_CMD) begin
          w_done_n = 1'b1;
        end else if (r_state != S_IDLE && r_state != S_ERR) begin
          w_err_n  = 1'b1;
          w_code_n = 2'b10;
        end
      end
    end else begin
      case (w_cur)
        S_CMD: begin
          if (w_take) begin
            w_hidx_n = 3'd0;
            if (ioctl_dout == 8'hC8) begin
              w_state_n = S_C8HDR;
            end else if (ioctl_dout == 8'hCA) begin
              w_state_n = S_CAHDR;
            end else begin
              w_state_n = S_ERR;
              w_err_n   = 1'b1;
              w_code_n  = 2'b01;
            end
          end
        end
        S_C8HDR: begin
          if (w_take) begin
            w_hidx_n = r_hidx + 3'd1;
            case (r_hidx)
              3'd0: w_seg_n[7:0]  = ioctl_dout;
              3'd1: w_seg_n[15:8] = ioctl_dout;
              3'd2: w_off_n[7:0]  = ioctl_dout;
              3'd3: w_off_n[15:8] = ioctl_dout;
              3'd6: w_rem_n[7:0]  = ioctl_dout;
              3'd7: begin
                w_rem_n = w_len;
                w_ptr_n = w_base_full[ADDR_W-1:0];
                if (w_len == 16'd0) begin
                  w_sec_n   = w_sec_inc;
                  w_state_n = S_CMD;
                end else begin
                  w_state_n = S_DATA;
                end
              end
              default: ;
            endcase
          end
        end
        S_DATA: begin
          if (w_take) begin
            w_addr_n   = r_ptr;
            w_dout_n   = ioctl_dout;
            w_ram_we_n = 1'b1;
            w_wait_n   = 1'b1;
            w_pcnt_n   = '0;
            w_state_n  = S_WR;
          end
        end
        S_WR: begin
          if (w_pulse_end) begin
            w_ram_we_n = 1'b0;
            w_state_n  = S_NEXT;
          end else begin
            w_pcnt_n = r_pcnt + PW'(1);
          end
        end
        S_NEXT: begin
          w_ptr_n  = r_ptr + ADDR_W'(1);
          w_rem_n  = r_rem - 16'd1;
          w_wait_n = 1'b0;
          if (r_rem == 16'd1) begin
            w_sec_n   = w_sec_inc;
            w_state_n = S_CMD;
          end else begin
            w_state_n = S_DATA;
          end
        end
        S_CAHDR: begin
          if (w_take) begin
            w_hidx_n = r_hidx + 3'd1;
            case (r_hidx)
              3'd0: w_seg_n[7:0]  = ioctl_dout;
              3'd1: w_seg_n[15:8] = ioctl_dout;
              3'd2: w_off_n[7:0]  = ioctl_dout;
              default: begin
                w_off_n[15:8] = ioctl_dout;
                w_wait_n      = 1'b1;
                w_vidx_n      = 3'd0;
                w_pcnt_n      = '0;
                w_rom_we_n    = 1'b1;
                w_addr_n      = rom_addr(3'd0);
                w_dout_n      = 8'hEA;
                w_state_n     = S_VEC;
              end
            endcase
          end
        end
        S_VEC: begin
          if (r_rom_we) begin
            if (w_pulse_end) w_rom_we_n = 1'b0;
            else             w_pcnt_n   = r_pcnt + PW'(1);
          end else if (r_vidx == 3'd4) begin
            w_eseg_n  = r_seg;
            w_eoff_n  = r_off;
            w_ev_n    = 1'b1;
            w_wait_n  = 1'b0;
            w_state_n = S_CMD;
          end else begin
            w_vidx_n   = r_vidx + 3'd1;
            w_pcnt_n   = '0;
            w_rom_we_n = 1'b1;
            w_addr_n   = rom_addr(r_vidx + 3'd1);
            w_dout_n   = vec_byte(r_vidx + 3'd1, r_seg, r_off);
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dl_q   <= 1'b0;
      r_hidx   <= '0;
      r_seg    <= '0;
      r_off    <= '0;
      r_rem    <= '0;
      r_ptr    <= '0;
      r_pcnt   <= '0;
      r_vidx   <= '0;
      r_wait   <= 1'b0;
      r_lrst   <= 1'b0;
      r_addr   <= '0;
      r_dout   <= '0;
      r_ram_we <= 1'b0;
      r_rom_we <= 1'b0;
      r_ev     <= 1'b0;
      r_eseg   <= '0;
      r_eoff   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_code   <= '0;
      r_sec    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_dl_q   <= ioctl_download;
      r_hidx   <= w_hidx_n;
      r_seg    <= w_seg_n;
      r_off    <= w_off_n;
      r_rem    <= w_rem_n;
      r_ptr    <= w_ptr_n;
      r_pcnt   <= w_pcnt_n;
      r_vidx   <= w_vidx_n;
      r_wait   <= w_wait_n;
      r_lrst   <= w_lrst_n;
      r_addr   <= w_addr_n;
      r_dout   <= w_dout_n;
      r_ram_we <= w_ram_we_n;
      r_rom_we <= w_rom_we_n;
      r_ev     <= w_ev_n;
      r_eseg   <= w_eseg_n;
      r_eoff   <= w_eoff_n;
      r_done   <= w_done_n;
      r_err    <= w_err_n;
      r_code   <= w_code_n;
      r_sec    <= w_sec_n;
    end
  end

  // Strobes are gated by the download line so an aborted download cuts them off at once
  assign ram_we      = r_ram_we & ioctl_download;
  assign rom_we      = r_rom_we & ioctl_download;
  assign ioctl_wait  = r_wait;
  assign load_reset  = r_lrst;
  assign mem_addr    = r_addr;
  assign mem_dout    = r_dout;
  assign entry_valid = r_ev;
  assign entry_seg   = r_eseg;
  assign entry_off   = r_eoff;
  assign done        = r_done;
  assign err         = r_err;
  assign err_code    = r_code;
  assign sections    = r_sec;

endmodule
